spi_operand_rx: RTL

SPI slave receiver that sits directly upstream of the signed `adder` in the SPI execution unit. It oversamples an SPI mode-0 link in the system clock domain and deserialises one frame of two signed `LEN`-bit operands, MSB first, A then B. It presents the operands on `o_a`/`o_b` together with a one-cycle `o_valid` strobe. Malformed frames are rejected with `o_frame_err`, and the outputs are left untouched.

---
 rtl/spi_exe_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_operand_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/spi_exe_pkg.sv
// Shared types and constants for the SPI execution unit.
package spi_exe_pkg;

  // Operand width shared by the SPI receiver and the downstream adder.
  localparam int OPERAND_LEN = 4;

  // Depth of every input synchroniser chain.
  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a delay register
// behind the last stage so rising/falling edges can be flagged for one cycle.
module spi_sync_edge
  import spi_exe_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // Next values of the synchroniser chain and the edge-detect delay stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // All stages clear to 0, so a line that idles high shows a rise after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = o_level & ~dly_q;
  assign o_fall  = ~o_level & dly_q;

endmodule

// File: rtl/spi_operand_rx.sv
// Oversampling SPI mode-0 slave that deserialises one frame of two signed
// operands (A then B, MSB first) and hands them to the adder with a strobe.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for cs_n to fall; sclk edges and cs_n rises ignored
// SHIFT | frame in progress; sclk rises shift mosi, cs_n rise ends it
module spi_operand_rx
  import spi_exe_pkg::*;
#(
  parameter int LEN = OPERAND_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic signed [LEN-1:0] o_a,
  output logic signed [LEN-1:0] o_b,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int FRAME = 2 * LEN;
  localparam int CW    = $clog2(2 * LEN + 2);
  localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME + 1);

  logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge u_sync_sclk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_d     (i_sclk),
    .o_level (sclk_lvl_unused),
    .o_rise  (sclk_rise),
    .o_fall  (sclk_fall_unused)
  );

  spi_sync_edge u_sync_cs (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_d     (i_cs_n),
    .o_level (cs_lvl_unused),
    .o_rise  (cs_rise),
    .o_fall  (cs_fall)
  );

  // mosi shares the sclk synchroniser depth so the bit seen alongside a
  // detected sclk rise is the one that was on the wire at that rise.
  spi_sync_edge u_sync_mosi (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_d     (i_mosi),
    .o_level (mosi_lvl),
    .o_rise  (mosi_rise_unused),
    .o_fall  (mosi_fall_unused)
  );

  rx_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FRAME-1:0]      sr_q, sr_d;
  logic signed [LEN-1:0] a_q, a_d;
  logic signed [LEN-1:0] b_q, b_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  // Frame FSM next-state: a coincident sclk rise is shifted and counted before
  // the end-of-frame check, which therefore looks at the updated count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          sr_d = {sr_q[FRAME-2:0], mosi_lvl};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        if (cs_rise) begin
          if (cnt_d == CNT_FRAME) begin
            a_d     = sr_d[FRAME-1:LEN];
            b_d     = sr_d[LEN-1:0];
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  // Single register bank for the FSM, datapath and all outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_a         = a_q;
  assign o_b         = b_q;
  assign o_valid     = valid_q;
  assign o_frame_err = err_q;
  assign o_busy      = busy_q;

endmodule
